// File: rtl/fir_coef_sequencer_pkg.sv
// Shared FIR coefficient package: sequencer state type, default widths and the sweep-size check.
// Also used by the coefficient write block.
package fir_coef_sequencer_pkg;

  localparam int unsigned FIR_COEF_W = 16;
  localparam int unsigned FIR_ADDR_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fir_seq_state_t;

  // A sweep is legal only when it has taps and every filter fits in the RAM.
  function automatic logic sweep_fits(input int unsigned num_filters,
                                      input int unsigned addr_w,
                                      input logic [7:0]  taps);
    longint unsigned need;
    longint unsigned cap;
    need = 64'(num_filters) * 64'(taps);
    cap  = 64'(1) << addr_w;
    return (taps != 8'd0) && (need <= cap);
  endfunction

endpackage

// File: rtl/fir_coef_sequencer_if.sv
// Coefficient stream from the sequencer to the FIR MAC array, with valid/ready and tap tags.
interface fir_coef_sequencer_if
  import fir_coef_sequencer_pkg::*;
#(
  parameter int unsigned COEF_W = FIR_COEF_W,
  parameter int unsigned FILT_W = 2
);
  logic [COEF_W-1:0] coef_out;
  logic              coef_valid;
  logic              mac_ready;
  logic [7:0]        tap_idx;
  logic [FILT_W-1:0] filter_idx;
  logic              first_tap;
  logic              last_tap;

  modport master (
    output coef_out, coef_valid, tap_idx, filter_idx, first_tap, last_tap,
    input  mac_ready
  );

  modport slave (
    input  coef_out, coef_valid, tap_idx, filter_idx, first_tap, last_tap,
    output mac_ready
  );
endinterface

// File: rtl/fir_coef_out_stage.sv
// Optional registered output stage for the coefficient stream: one output register plus a
// skid entry, so in_ready_o is a flop and full throughput holds while the sink is ready.
module fir_coef_out_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);
  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      // Skid drains first; input is blocked that cycle since in_ready_o is low.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_valid_i && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
endmodule

// File: rtl/fir_coef_sequencer.sv
// Read-side sweep of the FIR coefficient RAM: one pass over every tap of every filter per sample.
// Define FIR_COEF_OUT_REG_EN to register the coefficient stream through fir_coef_out_stage.
module fir_coef_sequencer
  import fir_coef_sequencer_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned ADDR_W      = FIR_ADDR_W,
  parameter int unsigned COEF_W      = FIR_COEF_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          taps_per_filter,
  input  logic                sample_strobe,
  output logic [ADDR_W-1:0]   coef_rd_addr,
  input  logic [COEF_W-1:0]   coef_rd_data,
  fir_coef_sequencer_if.master mac_if,
  output logic                busy,
  output logic                sweep_done,
  output logic                overrun
);
  localparam int unsigned FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [FILT_W-1:0] LastFilt = FILT_W'(NUM_FILTERS - 1);

  fir_seq_state_t    state_q, state_d;
  logic [7:0]        taps_q, taps_d;
  logic [7:0]        tap_q, tap_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overrun_q, overrun_d;

  logic issue;       // counters present an entry this cycle
  logic advance;     // that entry leaves the counters
  logic out_accept;  // MAC takes an entry
  logic out_final;   // ...and it is the last one of the sweep
  logic is_last_tap;
  logic final_entry;

  assign is_last_tap = (tap_q == taps_q - 8'd1);
  assign final_entry = is_last_tap && (filt_q == LastFilt);

`ifdef FIR_COEF_OUT_REG_EN
  localparam int unsigned PayloadW = 3 + FILT_W + 8 + COEF_W;

  logic                issued_all_q, issued_all_d;
  logic                stage_in_ready, stage_out_valid;
  logic [PayloadW-1:0] in_payload, out_payload, out_gated;
  logic                o_last, o_first;
  logic [FILT_W-1:0]   o_filt;
  logic [7:0]          o_tap;
  logic [COEF_W-1:0]   o_coef;

  assign issue      = (state_q == StRun) && !issued_all_q;
  assign advance    = issue && stage_in_ready;
  assign in_payload = {final_entry, is_last_tap, tap_q == 8'd0, filt_q, tap_q, coef_rd_data};

  fir_coef_out_stage #(
    .Width(PayloadW)
  ) u_out_stage (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (issue),
    .in_ready_o  (stage_in_ready),
    .in_data_i   (in_payload),
    .out_valid_o (stage_out_valid),
    .out_ready_i (mac_if.mac_ready),
    .out_data_o  (out_payload)
  );

  assign out_gated = stage_out_valid ? out_payload : '0;
  assign {out_final, o_last, o_first, o_filt, o_tap, o_coef} = out_gated;

  assign out_accept        = stage_out_valid && mac_if.mac_ready;
  assign mac_if.coef_valid = stage_out_valid;
  assign mac_if.coef_out   = o_coef;
  assign mac_if.tap_idx    = o_tap;
  assign mac_if.filter_idx = o_filt;
  assign mac_if.first_tap  = o_first;
  assign mac_if.last_tap   = o_last;

  // Stops the counters issuing once the final entry is in the stage; the sweep ends on its accept.
  always_comb begin
    issued_all_d = issued_all_q;
    if (state_q == StIdle && sample_strobe) begin
      issued_all_d = 1'b0;
    end else if (advance && final_entry) begin
      issued_all_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issued_all_q <= 1'b0;
    end else begin
      issued_all_q <= issued_all_d;
    end
  end
`else
  assign issue      = (state_q == StRun);
  assign advance    = issue && mac_if.mac_ready;
  assign out_accept = advance;
  assign out_final  = final_entry;

  assign mac_if.coef_valid = issue;
  assign mac_if.coef_out   = issue ? coef_rd_data : '0;
  assign mac_if.tap_idx    = tap_q;
  assign mac_if.filter_idx = filt_q;
  assign mac_if.first_tap  = issue && (tap_q == 8'd0);
  assign mac_if.last_tap   = issue && is_last_tap;
`endif

  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    tap_d     = tap_q;
    filt_d    = filt_q;
    addr_d    = addr_q;
    overrun_d = overrun_q | (sample_strobe && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (sample_strobe) begin
          taps_d  = taps_per_filter;
          tap_d   = 8'd0;
          filt_d  = '0;
          addr_d  = '0;
          state_d = sweep_fits(NUM_FILTERS, ADDR_W, taps_per_filter) ? StRun : StDone;
        end
      end
      StRun: begin
        if (advance) begin
          addr_d = addr_q + ADDR_W'(1);
          if (is_last_tap) begin
            tap_d  = 8'd0;
            filt_d = filt_q + FILT_W'(1);
          end else begin
            tap_d = tap_q + 8'd1;
          end
        end
        if (out_accept && out_final) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      taps_q    <= 8'd0;
      tap_q     <= 8'd0;
      filt_q    <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      taps_q    <= taps_d;
      tap_q     <= tap_d;
      filt_q    <= filt_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
    end
  end

  assign coef_rd_addr = addr_q;
  assign busy         = (state_q == StRun);
  assign sweep_done   = (state_q == StDone);
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed bench for fir_coef_sequencer: table of sweeps plus a mid-sweep reset sequence.
module tb_fir_coef_sequencer;
`ifdef FIR_COEF_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int MaxCycles = 600;

  typedef struct {
    logic [7:0] taps;
    bit         toggle;       // mac_ready 1,0,1,0,... instead of held high
    int         strobe_at;    // extra strobe in this sweep cycle (0 = none)
    int         exp_accepts;
    bit         exp_overrun;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  taps_per_filter = 8'd0;
  logic        sample_strobe = 1'b0;
  logic [7:0]  coef_rd_addr;
  logic [15:0] coef_rd_data;
  logic        busy, sweep_done, overrun;

  int checks = 0;
  int errors = 0;
  vec_t vecs[7];

  fir_coef_sequencer_if #(.COEF_W(16), .FILT_W(2)) mac_if ();

  fir_coef_sequencer #(
    .NUM_FILTERS(4),
    .ADDR_W     (8),
    .COEF_W     (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .taps_per_filter(taps_per_filter),
    .sample_strobe  (sample_strobe),
    .coef_rd_addr   (coef_rd_addr),
    .coef_rd_data   (coef_rd_data),
    .mac_if         (mac_if),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .overrun        (overrun)
  );

  // RAM preloaded with data = addr ^ 16'hA5A5, combinational read.
  assign coef_rd_data = {8'h00, coef_rd_addr} ^ 16'hA5A5;

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_entry(input int t, input int k);
    chk("tap_idx", mac_if.tap_idx, k % t);
    chk("filter_idx", mac_if.filter_idx, k / t);
    chk("first_tap", mac_if.first_tap, (k % t) == 0);
    chk("last_tap", mac_if.last_tap, (k % t) == t - 1);
    chk("coef_out", mac_if.coef_out, (k & 255) ^ 16'hA5A5);
`ifndef FIR_COEF_OUT_REG_EN
    chk("coef_rd_addr", coef_rd_addr, k & 255);
`endif
  endtask

  task automatic check_reset_state();
    chk("rst coef_rd_addr", coef_rd_addr, 0);
    chk("rst coef_out", mac_if.coef_out, 0);
    chk("rst coef_valid", mac_if.coef_valid, 0);
    chk("rst tap_idx", mac_if.tap_idx, 0);
    chk("rst filter_idx", mac_if.filter_idx, 0);
    chk("rst first_tap", mac_if.first_tap, 0);
    chk("rst last_tap", mac_if.last_tap, 0);
    chk("rst busy", busy, 0);
    chk("rst sweep_done", sweep_done, 0);
    chk("rst overrun", overrun, 0);
  endtask

  // Called at posedge+1; strobe goes into cycle 0, the sweep is observed from cycle 1.
  task automatic run_sweep(input vec_t v);
    int k = 0;
    int first_cyc = -1;
    int last_acc = -1;
    int done_cyc = -1;
    bit busy_seen = 1'b0;
    taps_per_filter = v.taps;
    sample_strobe = 1'b1;
    mac_if.mac_ready = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    taps_per_filter = ~v.taps;  // must be ignored for the rest of the sweep
    for (int cyc = 1; cyc <= MaxCycles && done_cyc < 0; cyc++) begin
      mac_if.mac_ready = v.toggle ? (cyc % 2 == 1) : 1'b1;
      sample_strobe = (cyc == v.strobe_at);
      #1;
      if (busy) busy_seen = 1'b1;
      if (mac_if.coef_valid && first_cyc < 0) first_cyc = cyc;
      if (mac_if.coef_valid && mac_if.mac_ready) begin
        check_entry(int'(v.taps), k);
        k++;
        last_acc = cyc;
      end
      if (sweep_done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    sample_strobe = 1'b0;
    mac_if.mac_ready = 1'b1;
    chk("sweep_done seen", done_cyc >= 0, 1);
    chk("accept count", k, v.exp_accepts);
    if (v.exp_accepts == 0) begin
      chk("no coef_valid", first_cyc, -1);
      chk("busy never", busy_seen, 0);
      chk("done cycle", done_cyc, 1);
    end else begin
      chk("first valid cycle", first_cyc, Lat);
      chk("done after last accept", done_cyc, last_acc + 1);
      if (!v.toggle) chk("done cycle", done_cyc, v.exp_accepts + Lat);
    end
    #1;
    chk("done one pulse", sweep_done, 0);
    chk("busy after done", busy, 0);
    chk("overrun", overrun, v.exp_overrun);
  endtask

  initial begin
    int n;
    vecs[0] = '{taps: 8'd4,  toggle: 1'b0, strobe_at: 0, exp_accepts: 16,  exp_overrun: 1'b0};
    vecs[1] = '{taps: 8'd3,  toggle: 1'b1, strobe_at: 0, exp_accepts: 12,  exp_overrun: 1'b0};
    vecs[2] = '{taps: 8'd0,  toggle: 1'b0, strobe_at: 0, exp_accepts: 0,   exp_overrun: 1'b0};
    vecs[3] = '{taps: 8'd65, toggle: 1'b0, strobe_at: 0, exp_accepts: 0,   exp_overrun: 1'b0};
    vecs[4] = '{taps: 8'd1,  toggle: 1'b0, strobe_at: 0, exp_accepts: 4,   exp_overrun: 1'b0};
    vecs[5] = '{taps: 8'd64, toggle: 1'b0, strobe_at: 0, exp_accepts: 256, exp_overrun: 1'b0};
    vecs[6] = '{taps: 8'd8,  toggle: 1'b0, strobe_at: 5, exp_accepts: 32,  exp_overrun: 1'b1};

    mac_if.mac_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_sweep(vecs[i]);

    // Reset in the middle of a sweep, then restart from address 0.
    taps_per_filter = 8'd4;
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    n = 0;
    while (coef_rd_addr != 8'd6 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach addr 6", coef_rd_addr, 6);
    chk("busy mid-sweep", busy, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state();
    reset_n = 1'b1;
    run_sweep(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
